// File: rtl/ahb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_ram_slave
// Brief    : AHB-Lite word-organised RAM slave with configurable wait states,
//            byte-lane writes and a two-cycle ERROR response for illegal accesses.
// Revision : 1.0
// ============================================================================
module ahb_ram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [MEM_WORDS];

    logic            w_accept;
    logic            w_illegal;
    logic            w_done;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [AW-1:0]   w_index;
    logic [3:0]      w_be;
    logic            w_ready;
    logic            w_resp;
    logic            unused_ok;

    assign unused_ok = ^{haddr[31:24], hprot, htrans[0]};

    assign w_accept  = hsel && hready && htrans[1];
    assign w_illegal = (hsize > 3'b010)
                    || ((hsize == 3'b001) && haddr[0])
                    || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
                    || ({10'd0, haddr[23:2]} >= 32'(MEM_WORDS));

    assign w_done  = (state_q == ST_WAIT) && (cnt_q == 3'd0);
    assign w_wr_en = w_done && write_q;
    assign w_rd_en = w_done && !write_q;
    assign w_index = addr_q[AW+1:2];

    always_comb begin
        w_ready = 1'b1;
        w_resp  = 1'b0;
        case (state_q)
            ST_WAIT: w_ready = (cnt_q == 3'd0);
            ST_ERR1: begin
                w_ready = 1'b0;
                w_resp  = 1'b1;
            end
            ST_ERR2: w_resp = 1'b1;
            default: ;
        endcase
    end

    assign hreadyout = w_ready;
    assign hresp     = w_resp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            ST_WAIT: if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            ST_ERR1: state_d = ST_ERR2;
            default: ;
        endcase
        // Any cycle where this slave is ready ends the current data phase and may open the next.
        if (w_ready) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            if (w_accept) begin
                addr_d  = haddr[AW+1:0];
                write_d = hwrite;
                size_d  = hsize;
                if (w_illegal) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'(WAIT_STATES);
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            if (w_rd_en) rdata_q <= mem[w_index];
        end
    end

    assign hrdata = w_rd_en ? mem[w_index] : rdata_q;

    always_comb begin
        w_be = 4'b0000;
        case (size_q)
            3'b000:  w_be = 4'b0001 << addr_q[1:0];
            3'b001:  w_be = addr_q[1] ? 4'b1100 : 4'b0011;
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Storage has no reset; an aborted write is suppressed because reset forces the FSM to IDLE.
    always_ff @(posedge hclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) mem[w_index][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_ram_slave
// Brief    : Scoreboard bench for ahb_ram_slave; instance 0 uses one wait
//            state, instance 1 none.
// Revision : 1.0
// ============================================================================
module tb_ahb_ram_slave;

    localparam int WS0 = 1;
    localparam int WS1 = 0;

    typedef struct {
        logic        err;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    logic        hclk;
    logic        hresetn;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    exp_t q [2][$];
    int   total = 0;
    int   bad   = 0;
    int   nwait [2];
    bit   pend  [2];

    ahb_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(WS0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr[0]),
        .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hprot(4'b0011),
        .hwdata(hwdata[0]), .hready(hreadyout[0]), .hreadyout(hreadyout[0]),
        .hresp(hresp[0]), .hrdata(hrdata[0])
    );

    ahb_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(WS1)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr[1]),
        .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hprot(4'b0011),
        .hwdata(hwdata[1]), .hready(hreadyout[1]), .hreadyout(hreadyout[1]),
        .hresp(hresp[1]), .hrdata(hrdata[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: follows each data phase and compares against the head of the queue.
    always @(negedge hclk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (!hresetn) begin
                pend[k]  = 1'b0;
                nwait[k] = 0;
            end else begin
                if (pend[k]) begin
                    if (q[k].size() == 0) begin
                        chk("queue_empty", 32'(q[k].size()), 32'd1);
                    end else if (!hreadyout[k]) begin
                        nwait[k]++;
                        chk("resp_during_wait", 32'(hresp[k]), 32'(q[k][0].err));
                    end else begin
                        e = q[k].pop_front();
                        chk("resp", 32'(hresp[k]), 32'(e.err));
                        chk("wait_cycles", 32'(nwait[k]), e.err ? 32'd1 : (k == 0 ? 32'(WS0) : 32'(WS1)));
                        if (!e.wr && !e.err) chk("rdata", hrdata[k], e.data);
                    end
                end
                if (hreadyout[k]) begin
                    pend[k]  = hsel[k] && htrans[k][1];
                    nwait[k] = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the address phase was accepted.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        bit   done;
        exp_t e;
        done      = 1'b0;
        hsel[k]   = 1'b1;
        haddr[k]  = addr;
        htrans[k] = 2'b10;
        hwrite[k] = wr;
        hsize[k]  = size;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge hclk);
            if (hreadyout[k]) begin
                e.err  = err;
                e.wr   = wr;
                e.data = rdata;
                q[k].push_back(e);
                done = 1'b1;
            end
            @(posedge hclk); #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        hwdata[k] = wdata;
    endtask

    task automatic idle(input int k, input int n);
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        repeat (n) @(posedge hclk);
        #1;
    endtask

    // Presents one phase that must not be treated as a transfer.
    task automatic noxfer(input int k, input logic sel, input logic [1:0] trans, input logic [31:0] addr);
        hsel[k]   = sel;
        htrans[k] = trans;
        haddr[k]  = addr;
        hwrite[k] = 1'b1;
        hsize[k]  = 3'b010;
        @(posedge hclk); #1;
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        hwdata[k] = 32'hFFFF_FFFF;
        @(negedge hclk);
        chk("ignored_ready", 32'(hreadyout[k]), 32'd1);
        chk("ignored_resp", 32'(hresp[k]), 32'd0);
        @(posedge hclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hsel[k] = 1'b0; haddr[k] = 32'd0; htrans[k] = 2'b00;
            hwrite[k] = 1'b0; hsize[k] = 3'b010; hwdata[k] = 32'd0;
        end
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 32'(hreadyout[k]), 32'd1);
            chk("reset_resp", 32'(hresp[k]), 32'd0);
            chk("reset_rdata", hrdata[k], 32'd0);
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;

        // Instance 0: one wait state
        xfer(0, 1'b1, 32'hB000_0010, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'hB000_0010, 3'b010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        idle(0, 2);
        xfer(0, 1'b1, 32'hB000_0010, 3'b010, 32'h1122_3344, 1'b0, 32'h0);
        xfer(0, 1'b1, 32'hB000_0013, 3'b000, 32'h55AA_BBCC, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'hB000_0010, 3'b010, 32'h0, 1'b0, 32'h5522_3344);
        xfer(0, 1'b1, 32'hB000_0001, 3'b001, 32'hFFFF_FFFF, 1'b1, 32'h0);
        xfer(0, 1'b0, 32'hB000_0010, 3'b010, 32'h0, 1'b0, 32'h5522_3344);
        xfer(0, 1'b1, 32'hB000_0012, 3'b001, 32'hBEEF_1234, 1'b0, 32'h0);
        xfer(0, 1'b1, 32'hB000_0010, 3'b000, 32'h0000_00A5, 1'b0, 32'h0);
        xfer(0, 1'b1, 32'hB000_0011, 3'b000, 32'h7777_C377, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'hB000_0010, 3'b010, 32'h0, 1'b0, 32'hBEEF_C3A5);
        xfer(0, 1'b1, 32'hB000_0012, 3'b010, 32'hFFFF_FFFF, 1'b1, 32'h0);
        xfer(0, 1'b0, 32'hB000_0010, 3'b011, 32'h0, 1'b1, 32'h0);
        xfer(0, 1'b0, 32'hB000_1000, 3'b010, 32'h0, 1'b1, 32'h0);
        xfer(0, 1'b1, 32'hB000_0FFC, 3'b010, 32'h0BAD_F00D, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'hB000_0FFC, 3'b010, 32'h0, 1'b0, 32'h0BAD_F00D);
        idle(0, 3);
        noxfer(0, 1'b1, 2'b01, 32'hB000_0010);
        noxfer(0, 1'b0, 2'b10, 32'hB000_0010);
        xfer(0, 1'b0, 32'hB000_0010, 3'b010, 32'h0, 1'b0, 32'hBEEF_C3A5);
        idle(0, 3);

        // Instance 1: zero wait states, back-to-back
        xfer(1, 1'b1, 32'hB000_0000, 3'b010, 32'hCAFE_F00D, 1'b0, 32'h0);
        xfer(1, 1'b0, 32'hB000_0000, 3'b010, 32'h0, 1'b0, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'hB000_0003, 3'b010, 32'h0, 1'b1, 32'h0);
        xfer(1, 1'b0, 32'hB000_0000, 3'b010, 32'h0, 1'b0, 32'hCAFE_F00D);
        idle(1, 3);

        // Reset during the wait cycle of a write
        xfer(0, 1'b1, 32'hB000_0020, 3'b010, 32'h0102_0304, 1'b0, 32'h0);
        xfer(0, 1'b0, 32'hB000_0020, 3'b010, 32'h0, 1'b0, 32'h0102_0304);
        idle(0, 3);
        xfer(0, 1'b1, 32'hB000_0020, 3'b010, 32'hFFFF_FFFF, 1'b0, 32'h0);
        hsel[0]   = 1'b0;
        htrans[0] = 2'b00;
        chk("pre_reset_wait", 32'(hreadyout[0]), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("abort_ready", 32'(hreadyout[0]), 32'd1);
        chk("abort_resp", 32'(hresp[0]), 32'd0);
        chk("abort_rdata", hrdata[0], 32'd0);
        q[0].delete();
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;
        xfer(0, 1'b0, 32'hB000_0020, 3'b010, 32'h0, 1'b0, 32'h0102_0304);
        idle(0, 4);

        chk("queue_drained", 32'(q[0].size() + q[1].size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_ram_slave.md
AHB_RAM_SLAVE -- requirements
Module: ahb_ram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, giving data-phase wait cycles (0..7).
REQ-003 SHALL have port hclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port hresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port hsel, input, 1 bit: slave select, driven by the decoder for the 0xB0xx_xxxx region.
REQ-006 SHALL have port haddr, input, 32 bits: transfer address.
REQ-007 SHALL have port htrans, input, 2 bits: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL have port hwrite, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port hsize, input, 3 bits: 000 byte, 001 half, 010 word.
REQ-010 SHALL have port hprot, input, 4 bits: accepted, ignored.
REQ-011 SHALL have port hwdata, input, 32 bits: write data, valid in the data phase.
REQ-012 SHALL have port hready, input, 1 bit: bus-level ready.
REQ-013 SHALL have port hreadyout, output, 1 bit: this slave's ready.
REQ-014 SHALL have port hresp, output, 1 bit: 0 OKAY, 1 ERROR.
REQ-015 SHALL have port hrdata, output, 32 bits: read data.

Function
REQ-016 SHALL capture an address phase only when hsel=1, hready=1 and htrans[1]=1, registering haddr, hwrite and hsize.
REQ-017 SHALL treat IDLE and BUSY, or hsel=0, as no transfer; the following cycle then gives hreadyout=1 and hresp=0.
REQ-018 SHALL use the FSM states IDLE, WAIT, ERR1 and ERR2.
REQ-019 SHALL, on an accepted legal transfer, go to WAIT with wait counter = WAIT_STATES and hold hreadyout=0 while the counter is nonzero, decrementing it each cycle.
REQ-020 SHALL, when WAIT_STATES=0 or the counter reaches 0, drive hreadyout=1 and hresp=0; that cycle completes the data phase.
REQ-021 SHALL flag a transfer as illegal if hsize>010, hsize=001 with haddr[0]=1, hsize=010 with haddr[1:0]!=00, or word index haddr[23:2] >= MEM_WORDS.
REQ-022 SHALL answer an illegal transfer with the two-cycle ERROR response: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), and SHALL NOT access memory.
REQ-023 SHALL, on a write, update memory in the completing cycle, writing only the byte lanes selected by the captured haddr[1:0] and hsize (byte: 1 lane; half: lanes 1:0 or 3:2; word: all lanes).
REQ-024 SHALL, on a read, present the full 32-bit word at the captured address on hrdata in the completing cycle (no lane masking), and SHALL hold hrdata at its last value otherwise.
REQ-025 SHALL accept a new address phase in the completing cycle of the current transfer (pipelined back-to-back), with no idle cycle inserted.
REQ-026 SHALL, for a read immediately following a write to the same word, return the newly written data.
REQ-027 SHALL ignore an address phase presented while hreadyout=0, because hready is 0 in that cycle.
REQ-028 SHALL, if the master drives IDLE in ERR2, return to IDLE; a new NONSEQ in ERR2 SHALL be accepted.

Reset
REQ-029 SHALL, while hresetn=0, force state=IDLE, wait counter=0, hreadyout=1, hresp=0 and hrdata=0, regardless of the clock.
REQ-030 SHALL abort an in-flight transfer on reset: no memory write occurs and no ERROR is issued. Memory contents are not reset.

Verification
REQ-031 Word write 0xDEADBEEF to 0xB000_0010, then word read of the same address with WAIT_STATES=1 -> hreadyout low for 1 cycle, hrdata=0xDEADBEEF, hresp=0.
REQ-032 Byte write 0x55 to 0xB000_0013 over word 0x11223344 -> subsequent read returns 0x55223344.
REQ-033 Half write to 0xB000_0001 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); memory unchanged.
REQ-034 Back-to-back NONSEQ write to 0xB000_0000 followed by read of 0xB000_0000 with WAIT_STATES=0 -> read returns the written data, no idle cycles inserted.
REQ-035 Read of word index 1024 (haddr=0xB000_1000) with MEM_WORDS=1024 -> two-cycle ERROR response.
REQ-036 hresetn asserted during a WAIT cycle of a write -> hreadyout=1 and hresp=0 immediately; target word unchanged.
